// File: rtl/branch_predictor.sv
// Direct-mapped branch history table with branch target buffer.
// Fetch side: zero-latency lookup of pred_pc from registered state.
// Resolve side: trains 2-bit saturating counters and targets, and keeps
// saturating branch / mispredict statistics.
module branch_predictor #(
  parameter int IDX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        clear,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int N     = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;

  logic [N-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q    [N];
  logic [TAG_W-1:0]  tag_d    [N];
  logic [31:0]       target_q [N];
  logic [31:0]       target_d [N];
  logic [1:0]        ctr_q    [N];
  logic [1:0]        ctr_d    [N];
  logic [31:0]       stat_branches_q, stat_branches_d;
  logic [31:0]       stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX_BITS-1:0] p_idx, u_idx;
  logic [TAG_W-1:0]    p_tag, u_tag;
  logic                u_hit;
  logic                mispredict;

  assign p_idx = pred_pc[IDX_BITS+1:2];
  assign p_tag = pred_pc[31:IDX_BITS+2];
  assign u_idx = upd_pc[IDX_BITS+1:2];
  assign u_tag = upd_pc[31:IDX_BITS+2];

  // Lookup from registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    pred_hit    = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
    pred_taken  = pred_hit && ctr_q[p_idx][1];
    pred_target = pred_taken ? target_q[p_idx] : pred_pc + 32'd4;
  end

  // Table training: clear wins over a same-cycle update; not-taken misses never allocate.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    if (clear) begin
      valid_d = '0;
      for (int i = 0; i < N; i++) ctr_d[i] = 2'b01;
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'b01;
          target_d[u_idx] = upd_target;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_d[u_idx] = ctr_q[u_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = upd_target;
        ctr_d[u_idx]    = 2'b10;
      end
    end
  end

  // Saturating statistics; a target miss only counts when both sides said taken.
  always_comb begin
    mispredict = (upd_pred_taken != upd_taken) ||
                 (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_valid && (stat_branches_q != 32'hFFFF_FFFF))
      stat_branches_d = stat_branches_q + 32'd1;
    if (upd_valid && mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF))
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  // State registers with asynchronous reset to weak-not-taken, invalid entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q            <= '0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      ctr_q              <= ctr_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule
